// File: rtl/regsrv_pkg.sv
// Shared widths and the response record for the register-file port server.
package regsrv_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int STAT_W = 16;

  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] data;
  } rsp_t;
endpackage

// File: rtl/regfile_port_server_if.sv
// Request and response valid/ready channels of the register-file port server.
interface regfile_port_server_if #(
  parameter int DATA_W = regsrv_pkg::DATA_W,
  parameter int ADDR_W = regsrv_pkg::ADDR_W
);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWData;
  logic              RspValid;
  logic              RspReady;
  logic              RspWrite;
  logic [DATA_W-1:0] RspData;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady,
    input  ReqReady, RspValid, RspWrite, RspData
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady,
    output ReqReady, RspValid, RspWrite, RspData
  );
endinterface

// File: rtl/regsrv_rsp_fifo.sv
// Response FIFO; while empty the head output keeps the last popped entry.
module regsrv_rsp_fifo
  import regsrv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             push,
  input  rsp_t             push_data,
  input  logic             pop,
  output rsp_t             head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_t             mem_q [DEPTH];
  rsp_t             mem_d [DEPTH];
  rsp_t             last_q, last_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/regfile_port_server.sv
// Register file behind a request/response handshake; register 0 reads as zero.
// Define REGSRV_STATS_EN to add saturating read/write counters with StatClear.
module regfile_port_server #(
  parameter int DATA_W    = regsrv_pkg::DATA_W,
  parameter int ADDR_W    = regsrv_pkg::ADDR_W,
  parameter int RSP_DEPTH = 2
) (
  input logic                  Clk,
  input logic                  Rst_n,
  regfile_port_server_if.slave bus
`ifdef REGSRV_STATS_EN
  ,
  input  logic                          StatClear,
  output logic [regsrv_pkg::STAT_W-1:0] StatReads,
  output logic [regsrv_pkg::STAT_W-1:0] StatWrites
`endif
);
  import regsrv_pkg::*;

  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [DATA_W-1:0] storage_q [NREG];
  logic [DATA_W-1:0] storage_d [NREG];
  logic              accept, addr_zero, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  rsp_count;
  rsp_t              push_rsp, head_rsp;

  // Ready depends only on the registered occupancy, never on RspReady.
  assign bus.ReqReady = (rsp_count < CNT_W'(RSP_DEPTH));
  assign accept       = bus.ReqValid && bus.ReqReady;
  assign addr_zero    = (bus.ReqAddr == '0);

  always_comb begin
    push_rsp.write = bus.ReqWrite;
    if (addr_zero) push_rsp.data = '0;
    else if (bus.ReqWrite) push_rsp.data = bus.ReqWData;
    else push_rsp.data = storage_q[bus.ReqAddr];
  end

  always_comb begin
    storage_d = storage_q;
    if (accept && bus.ReqWrite && !addr_zero) storage_d[bus.ReqAddr] = bus.ReqWData;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) storage_q[i] <= '0;
    end else begin
      storage_q <= storage_d;
    end
  end

  regsrv_rsp_fifo #(.DEPTH(RSP_DEPTH), .CNT_W(CNT_W)) u_rsp_fifo (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .push      (accept && !fifo_full),
    .push_data (push_rsp),
    .pop       (bus.RspValid && bus.RspReady),
    .head      (head_rsp),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rsp_count)
  );

  assign bus.RspValid = !fifo_empty;
  assign bus.RspWrite = head_rsp.write;
  assign bus.RspData  = head_rsp.data;

`ifdef REGSRV_STATS_EN
  logic [STAT_W-1:0] stat_reads_q, stat_reads_d, stat_writes_q, stat_writes_d;

  always_comb begin
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    if (StatClear) begin
      stat_reads_d  = '0;
      stat_writes_d = '0;
    end else if (accept) begin
      if (bus.ReqWrite && stat_writes_q != '1) stat_writes_d = stat_writes_q + 1'b1;
      if (!bus.ReqWrite && stat_reads_q != '1) stat_reads_d = stat_reads_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  end

  assign StatReads  = stat_reads_q;
  assign StatWrites = stat_writes_q;
`endif
endmodule

// File: doc/regfile_port_server.md
Name: regfile_port_server

Overview:
- Transaction-level responder wrapped around the 32x32 register file storage.
- Accepts read/write requests on a valid/ready channel and returns one response per request on a second valid/ready channel.
- Register 0 is hardwired to zero.
- Sits between a bus or test master and the register storage, so that directed testers and the CPU debug path drive it through the same handshake.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register address width; storage holds 2**ADDR_W entries
RSP_DEPTH, 2, response FIFO depth (power of 2, >=2)

Ports:
Clk  input  1  clock, all state updates on posedge
Rst_n  input  1  asynchronous active-low reset
ReqValid  input  1  request present
ReqReady  output  1  request accepted when ReqValid && ReqReady at posedge
ReqWrite  input  1  1 = write, 0 = read
ReqAddr  input  ADDR_W  target register
ReqWData  input  DATA_W  write data (ignored on reads)
RspValid  output  1  response present at FIFO head
RspReady  input  1  response consumed when RspValid && RspReady at posedge
RspWrite  output  1  echo of ReqWrite for the head response
RspData  output  DATA_W  read: register contents at accept; write: value actually stored (0 when ReqAddr==0)

Behaviour:
- Reset (async assert, sync deassert handled by the reset source):
  - all storage entries = 0
  - FIFO count = 0; RspValid = 0; RspData = 0; RspWrite = 0; ReqReady = 1 once Rst_n is high
- Accept = ReqValid && ReqReady. ReqReady = (count < RSP_DEPTH), registered from count. There is no combinational path from RspReady to ReqReady.
- On accept of a write to addr != 0: storage[addr] <= ReqWData at that edge; response {1, ReqWData} pushed at the same edge.
- On accept of a write to addr 0: storage unchanged; response {1, 0} pushed.
- On accept of a read: response {0, storage[addr]} pushed at the same edge. The read returns the value before that edge; the read itself never modifies storage. Reads of addr 0 always return 0.
- Latency: RspValid is high the cycle after accept when the FIFO was empty. Back-to-back accepts are allowed every cycle while not full.
- Read after write: if a write is accepted in cycle N and a read of the same address in cycle N+1, the read returns the new value.
- Push and pop in the same cycle: count unchanged; head and tail pointers both advance; wrap modulo RSP_DEPTH.
- Full (count == RSP_DEPTH): ReqReady = 0. A pop in that cycle makes ReqReady = 1 on the next cycle.
- Empty: RspValid = 0. RspData and RspWrite hold their last value (no X).
- RspValid, RspData and RspWrite stay stable while RspValid && !RspReady.
- Rst_n asserted mid-operation: pending responses are discarded and storage is cleared immediately.

Optional Feature:
- Macro REGSRV_STATS_EN.
- Defined: adds ports StatClear input 1, StatReads output 16 and StatWrites output 16.
  - Counters increment on each accepted read or write respectively (writes to addr 0 count).
  - Counters saturate at 16'hFFFF.
  - StatClear is synchronous and takes priority over an increment in the same cycle.
  - Both counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package regsrv_pkg holds:
  - DATA_W and ADDR_W defaults
  - STAT_W = 16
  - rsp_t typedef {logic write; logic [DATA_W-1:0] data}
- Sub-module regsrv_rsp_fifo: synchronous FIFO of rsp_t, RSP_DEPTH entries, with push, pop, full, empty and count. Same Clk/Rst_n.
- Storage, address-0 masking and request accept logic live in the top module.

Test Plan:
- After reset, read addr 2 with RspReady=1 -> RspValid the next cycle, RspWrite=0, RspData=0.
- Write 42 to addr 2, then read addr 2 in the immediately following cycle -> responses {1,42} then {0,42}, in order, on consecutive cycles.
- Write 42 to addr 0, then read addr 0 -> responses {1,0} and {0,0}; no storage change visible at addr 0.
- Write 15 to addr 3 and 99 to addr 2, then read addr 2 and addr 3 -> 99 and 15; no cross-register corruption.
- Hold RspReady=0 and issue 3 reads -> ReqReady falls after the 2nd accept and the 3rd stalls. Raise RspReady -> both responses drain in order, then the 3rd is accepted with response data correct.
- With REGSRV_STATS_EN: 3 writes and 2 reads -> StatWrites=3, StatReads=2. StatClear together with an accepted read -> both counters 0 the next cycle. Assert Rst_n low with 2 pending responses -> RspValid=0 immediately, and all counters and storage read back 0.
